md5_block_engine: RTL and testbench



---
 rtl/md5_block_engine.sv | 188 ++++++++++++++++++
 tb/tb_md5_block_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/md5_block_engine.sv
// md5_block_engine: iterative MD5 compression of one 512-bit block.
// UNROLL steps are chained combinationally per clock. The chaining value
// is added back in the FINAL cycle. Blocks and results move through
// ready/valid handshakes.
module md5_block_engine #(
  parameter int UNROLL    = 1,
  parameter bit CHAIN_ADD = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  output logic         ready_o,
  input  logic [511:0] msg_i,
  input  logic [127:0] digest_i,
  output logic [127:0] digest_o,
  output logic         valid_o,
  input  logic         ack_i,
  output logic         busy_o
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $error("md5_block_engine: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    step_q;
  logic [511:0]  msg_q;
  logic [127:0]  chain_q;
  logic [127:0]  digest_q;
  logic [31:0]   a_q, b_q, c_q, d_q;
  logic [31:0]   wa, wb, wc, wd, fsum, tmp;
  logic [5:0]    g;

  // Sine-derived additive constants, one per step
  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    k_rom = '0;
    case (idx)
      6'd0:  k_rom = 32'hd76aa478; 6'd1:  k_rom = 32'he8c7b756; 6'd2:  k_rom = 32'h242070db; 6'd3:  k_rom = 32'hc1bdceee;
      6'd4:  k_rom = 32'hf57c0faf; 6'd5:  k_rom = 32'h4787c62a; 6'd6:  k_rom = 32'ha8304613; 6'd7:  k_rom = 32'hfd469501;
      6'd8:  k_rom = 32'h698098d8; 6'd9:  k_rom = 32'h8b44f7af; 6'd10: k_rom = 32'hffff5bb1; 6'd11: k_rom = 32'h895cd7be;
      6'd12: k_rom = 32'h6b901122; 6'd13: k_rom = 32'hfd987193; 6'd14: k_rom = 32'ha679438e; 6'd15: k_rom = 32'h49b40821;
      6'd16: k_rom = 32'hf61e2562; 6'd17: k_rom = 32'hc040b340; 6'd18: k_rom = 32'h265e5a51; 6'd19: k_rom = 32'he9b6c7aa;
      6'd20: k_rom = 32'hd62f105d; 6'd21: k_rom = 32'h02441453; 6'd22: k_rom = 32'hd8a1e681; 6'd23: k_rom = 32'he7d3fbc8;
      6'd24: k_rom = 32'h21e1cde6; 6'd25: k_rom = 32'hc33707d6; 6'd26: k_rom = 32'hf4d50d87; 6'd27: k_rom = 32'h455a14ed;
      6'd28: k_rom = 32'ha9e3e905; 6'd29: k_rom = 32'hfcefa3f8; 6'd30: k_rom = 32'h676f02d9; 6'd31: k_rom = 32'h8d2a4c8a;
      6'd32: k_rom = 32'hfffa3942; 6'd33: k_rom = 32'h8771f681; 6'd34: k_rom = 32'h6d9d6122; 6'd35: k_rom = 32'hfde5380c;
      6'd36: k_rom = 32'ha4beea44; 6'd37: k_rom = 32'h4bdecfa9; 6'd38: k_rom = 32'hf6bb4b60; 6'd39: k_rom = 32'hbebfbc70;
      6'd40: k_rom = 32'h289b7ec6; 6'd41: k_rom = 32'heaa127fa; 6'd42: k_rom = 32'hd4ef3085; 6'd43: k_rom = 32'h04881d05;
      6'd44: k_rom = 32'hd9d4d039; 6'd45: k_rom = 32'he6db99e5; 6'd46: k_rom = 32'h1fa27cf8; 6'd47: k_rom = 32'hc4ac5665;
      6'd48: k_rom = 32'hf4292244; 6'd49: k_rom = 32'h432aff97; 6'd50: k_rom = 32'hab9423a7; 6'd51: k_rom = 32'hfc93a039;
      6'd52: k_rom = 32'h655b59c3; 6'd53: k_rom = 32'h8f0ccc92; 6'd54: k_rom = 32'hffeff47d; 6'd55: k_rom = 32'h85845dd1;
      6'd56: k_rom = 32'h6fa87e4f; 6'd57: k_rom = 32'hfe2ce6e0; 6'd58: k_rom = 32'ha3014314; 6'd59: k_rom = 32'h4e0811a1;
      6'd60: k_rom = 32'hf7537e82; 6'd61: k_rom = 32'hbd3af235; 6'd62: k_rom = 32'h2ad7d2bb; 6'd63: k_rom = 32'heb86d391;
      default: k_rom = '0;
    endcase
  endfunction

  // Rotate amount depends on the round and the step position within a group of four
  function automatic logic [4:0] shift_amt(input logic [5:0] idx);
    shift_amt = 5'd0;
    case ({idx[5:4], idx[1:0]})
      4'h0: shift_amt = 5'd7;  4'h1: shift_amt = 5'd12; 4'h2: shift_amt = 5'd17; 4'h3: shift_amt = 5'd22;
      4'h4: shift_amt = 5'd5;  4'h5: shift_amt = 5'd9;  4'h6: shift_amt = 5'd14; 4'h7: shift_amt = 5'd20;
      4'h8: shift_amt = 5'd4;  4'h9: shift_amt = 5'd11; 4'ha: shift_amt = 5'd16; 4'hb: shift_amt = 5'd23;
      4'hc: shift_amt = 5'd6;  4'hd: shift_amt = 5'd10; 4'he: shift_amt = 5'd15; 4'hf: shift_amt = 5'd21;
      default: shift_amt = 5'd0;
    endcase
  endfunction

  // Message word order per round; the multipliers are taken mod 16 so only g[3:0] matters
  function automatic logic [3:0] msg_index(input logic [5:0] idx);
    logic [3:0] gl;
    gl = idx[3:0];
    msg_index = gl;
    case (idx[5:4])
      2'd0:    msg_index = gl;
      2'd1:    msg_index = gl * 4'd5 + 4'd1;
      2'd2:    msg_index = gl * 4'd3 + 4'd5;
      default: msg_index = gl * 4'd7;
    endcase
  endfunction

  // Per-round boolean mixing function
  function automatic logic [31:0] round_f(input logic [5:0] idx, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    case (idx[5:4])
      2'd0:    round_f = (b & c) | (~b & d);
      2'd1:    round_f = (b & d) | (c & ~d);
      2'd2:    round_f = b ^ c ^ d;
      default: round_f = c ^ (b | ~d);
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    rotl = (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  // Chain UNROLL steps starting at the current step index
  always_comb begin
    wa   = a_q;
    wb   = b_q;
    wc   = c_q;
    wd   = d_q;
    g    = step_q;
    fsum = '0;
    tmp  = '0;
    for (int i = 0; i < UNROLL; i++) begin
      g    = step_q + 6'(i);
      fsum = wa + k_rom(g) + msg_q[{msg_index(g), 5'd0} +: 32] + round_f(g, wb, wc, wd);
      tmp  = wd;
      wd   = wc;
      wc   = wb;
      wb   = wb + rotl(fsum, shift_amt(g));
      wa   = tmp;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (step_q == 6'(64 - UNROLL)) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Block capture, round iteration and final chaining add
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q   <= '0;
      msg_q    <= '0;
      chain_q  <= '0;
      digest_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            msg_q   <= msg_i;
            chain_q <= digest_i;
            a_q     <= digest_i[31:0];
            b_q     <= digest_i[63:32];
            c_q     <= digest_i[95:64];
            d_q     <= digest_i[127:96];
            step_q  <= '0;
          end
        end
        RUN: begin
          a_q    <= wa;
          b_q    <= wb;
          c_q    <= wc;
          d_q    <= wd;
          step_q <= step_q + 6'(UNROLL);
        end
        FINAL: begin
          if (CHAIN_ADD)
            digest_q <= {d_q + chain_q[127:96], c_q + chain_q[95:64],
                         b_q + chain_q[63:32], a_q + chain_q[31:0]};
          else
            digest_q <= {d_q, c_q, b_q, a_q};
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == RUN) || (state_q == FINAL);
  assign valid_o  = (state_q == DONE);
  assign digest_o = digest_q;

endmodule

// File: tb/tb_md5_block_engine.sv
// tb_md5_block_engine: directed vectors for md5_block_engine across UNROLL
// and CHAIN_ADD variants, covering handshake, abort and back-to-back blocks.
module tb_md5_block_engine;

  localparam logic [127:0] IV        = 128'h10325476_98badcfe_efcdab89_67452301;
  localparam logic [127:0] EMPTY_DIG = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] EMPTY_RAW = 128'h6e10a476_ff4ea3eb_14e45506_7246fad3;
  localparam logic [127:0] ABC_DIG   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
  localparam int S_TAB [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  logic         clk, rst;
  logic [511:0] msg;
  logic [127:0] dig;
  logic [4:0]   start_v, ack_v, ready_v, valid_v, busy_v;
  logic [127:0] dout [5];
  logic [511:0] empty_msg, abc_msg;

  int vec_count, miss_count;
  int lat [5];
  int exp_lat [5] = '{65, 33, 17, 9, 17};
  logic [127:0] exp_dig [5];
  int busy_cnt, stable_bad, seen, n_valid, v1, v2;
  logic [127:0] held, got, d1, d2;
  logic v_after, r_after;

  md5_block_engine #(.UNROLL(1), .CHAIN_ADD(1)) u_eng1 (.clk_i(clk), .rst_i(rst), .start_i(start_v[0]),
    .ready_o(ready_v[0]), .msg_i(msg), .digest_i(dig), .digest_o(dout[0]), .valid_o(valid_v[0]),
    .ack_i(ack_v[0]), .busy_o(busy_v[0]));
  md5_block_engine #(.UNROLL(2), .CHAIN_ADD(1)) u_eng2 (.clk_i(clk), .rst_i(rst), .start_i(start_v[1]),
    .ready_o(ready_v[1]), .msg_i(msg), .digest_i(dig), .digest_o(dout[1]), .valid_o(valid_v[1]),
    .ack_i(ack_v[1]), .busy_o(busy_v[1]));
  md5_block_engine #(.UNROLL(4), .CHAIN_ADD(1)) u_eng4 (.clk_i(clk), .rst_i(rst), .start_i(start_v[2]),
    .ready_o(ready_v[2]), .msg_i(msg), .digest_i(dig), .digest_o(dout[2]), .valid_o(valid_v[2]),
    .ack_i(ack_v[2]), .busy_o(busy_v[2]));
  md5_block_engine #(.UNROLL(8), .CHAIN_ADD(1)) u_eng8 (.clk_i(clk), .rst_i(rst), .start_i(start_v[3]),
    .ready_o(ready_v[3]), .msg_i(msg), .digest_i(dig), .digest_o(dout[3]), .valid_o(valid_v[3]),
    .ack_i(ack_v[3]), .busy_o(busy_v[3]));
  md5_block_engine #(.UNROLL(4), .CHAIN_ADD(0)) u_eng_raw (.clk_i(clk), .rst_i(rst), .start_i(start_v[4]),
    .ready_o(ready_v[4]), .msg_i(msg), .digest_i(dig), .digest_o(dout[4]), .valid_o(valid_v[4]),
    .ack_i(ack_v[4]), .busy_o(busy_v[4]));

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MD5 compression of one block, straight from the RFC 1321 description
  function automatic logic [127:0] md5_ref(input logic [511:0] m, input logic [127:0] iv);
    logic [31:0] a, b, c, d, f;
    int gi, sh;
    a = iv[31:0]; b = iv[63:32]; c = iv[95:64]; d = iv[127:96];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); gi = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); gi = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          gi = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       gi = (7 * i) % 16; end
      sh = S_TAB[i / 16][i % 4];
      f  = f + a + K_TAB[i] + m[32 * gi +: 32];
      a  = d; d = c; c = b;
      b  = b + ((f << sh) | (f >> (32 - sh)));
    end
    return {d + iv[127:96], c + iv[95:64], b + iv[63:32], a + iv[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present a block on the falling edge and return just after the accepting edge
  task automatic applyStimulus(input logic [511:0] m, input logic [127:0] d, input logic [4:0] mask);
    @(negedge clk);
    msg     = m;
    dig     = d;
    start_v = mask;
    @(posedge clk);
    #1;
    start_v = '0;
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    empty_msg  = 512'h80;
    abc_msg    = (512'h18 << (32 * 14)) | 512'h80636261;
    exp_dig    = '{EMPTY_DIG, EMPTY_DIG, EMPTY_DIG, EMPTY_DIG, EMPTY_RAW};
    rst = 1'b1; msg = '0; dig = '0; start_v = '0; ack_v = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 128'(ready_v[0]), 128'd1);
    checkOutput("reset_valid", 128'(valid_v[0]), 128'd0);
    checkOutput("reset_busy",  128'(busy_v[0]),  128'd0);
    checkOutput("reset_digest", dout[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Empty block on every variant, with start pulses and input changes while busy/done
    applyStimulus(empty_msg, IV, 5'b11111);
    busy_cnt   = busy_v[0] ? 1 : 0;
    stable_bad = 0;
    held       = '0;
    for (int k = 0; k < 5; k++) lat[k] = 0;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      if (cyc == 10 || cyc == 80) begin
        msg = abc_msg; dig = '0; start_v = 5'b11111;
      end else begin
        start_v = '0;
      end
      @(posedge clk);
      #1;
      if (busy_v[0]) busy_cnt++;
      for (int k = 0; k < 5; k++)
        if (valid_v[k] && lat[k] == 0) lat[k] = cyc;
      if (lat[0] != 0 && cyc > lat[0]) begin
        if (dout[0] !== held) stable_bad++;
        if (ready_v[0] || !valid_v[0]) stable_bad++;
      end
      if (lat[0] != 0 && cyc == lat[0]) held = dout[0];
    end
    start_v = '0;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("latency_%0d", k), 128'(lat[k]), 128'(exp_lat[k]));
      checkOutput($sformatf("empty_digest_%0d", k), dout[k], exp_dig[k]);
    end
    checkOutput("busy_cycles", 128'(busy_cnt), 128'd65);
    checkOutput("done_hold_stable", 128'(stable_bad), 128'd0);
    @(negedge clk);
    ack_v = 5'b11111;
    @(posedge clk);
    #1;
    checkOutput("ack_valid_drop", 128'(valid_v[0]), 128'd0);
    checkOutput("ack_ready_next", 128'(ready_v[0]), 128'd1);
    @(negedge clk);
    ack_v = '0;

    // Abort at step 30 with an asynchronous reset
    applyStimulus(empty_msg, IV, 5'b00001);
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy",   128'(busy_v[0]),  128'd0);
    checkOutput("abort_ready",  128'(ready_v[0]), 128'd1);
    checkOutput("abort_valid",  128'(valid_v[0]), 128'd0);
    checkOutput("abort_digest", dout[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // "abc" block with ack already high
    @(negedge clk);
    ack_v[0] = 1'b1;
    applyStimulus(abc_msg, IV, 5'b00001);
    seen = 0; got = '0; v_after = 1'b1; r_after = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      #1;
      if (seen != 0 && cyc == seen + 1) begin
        v_after = valid_v[0];
        r_after = ready_v[0];
      end
      if (valid_v[0] && seen == 0) begin
        seen = cyc;
        got  = dout[0];
      end
    end
    checkOutput("abc_latency", 128'(seen), 128'd65);
    checkOutput("abc_digest", got, ABC_DIG);
    checkOutput("early_ack_valid", 128'(v_after), 128'd0);
    checkOutput("early_ack_ready", 128'(r_after), 128'd1);

    // Back-to-back: start held high, second block chained on the first result
    @(negedge clk);
    msg = empty_msg; dig = IV; start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    msg = abc_msg; dig = EMPTY_DIG;
    n_valid = 0; v1 = 0; v2 = 0; d1 = '0; d2 = '0;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      @(posedge clk);
      #1;
      if (valid_v[0]) begin
        if (n_valid == 0) begin v1 = cyc; d1 = dout[0]; end
        else if (n_valid == 1) begin v2 = cyc; d2 = dout[0]; start_v[0] = 1'b0; end
        n_valid++;
      end
    end
    start_v[0] = 1'b0;
    checkOutput("b2b_first_latency",  128'(v1), 128'd65);
    checkOutput("b2b_first_digest",   d1, EMPTY_DIG);
    checkOutput("b2b_second_latency", 128'(v2), 128'd132);
    checkOutput("b2b_second_digest",  d2, md5_ref(abc_msg, EMPTY_DIG));
    checkOutput("b2b_idle_after", 128'(ready_v[0]), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
